c4_move_ctrl: RTL and testbench

Sequences all writes into the 6x7 Connect4 board RAM (42 cells, one token code per cell). It clears the board, accepts column-drop requests, and computes the landing row from per-column height counters. It writes the current player's token, alternates players and tracks draw. It sits between the player-input/UI logic and the board RAM's single write port, and is the only writer of that RAM.

---
 rtl/c4_move_ctrl_if.sv | 23 ++
 rtl/c4_move_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_c4_move_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/c4_move_ctrl_if.sv
// Move-request handshake and board-RAM write port of the Connect4 move controller.
// The master side is the player/UI logic plus RAM; the slave side is c4_move_ctrl.
interface c4_move_ctrl_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32
);
    logic                     move_valid;
    logic [2:0]               move_col;
    logic                     move_ready;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]    mem_wdata;
    logic                     mem_we;

    modport master (
        output move_valid, move_col,
        input  move_ready, mem_addr, mem_wdata, mem_we
    );

    modport slave (
        input  move_valid, move_col,
        output move_ready, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/c4_move_ctrl.sv
// Connect4 move controller: sole writer of the 6x7 board RAM (clear, drop, player turn, draw).
// Optional macro WIN_CHECK_EN adds a 4-cycle win check reading the board bus after each drop.
module c4_move_ctrl #(
    parameter int ROWS          = 6,
    parameter int COLS          = 7,
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    c4_move_ctrl_if.slave                   bus,
    input  logic                            new_game,
    input  logic [DATA_WIDTH*ROWS*COLS-1:0] board,
    output logic [1:0]                      player,
    output logic                            move_done,
    output logic                            move_err,
    output logic                            busy,
    output logic                            game_over,
    output logic                            draw,
    output logic [1:0]                      winner
);
    localparam int CELLS = ROWS * COLS;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_WRITE,
`ifdef WIN_CHECK_EN
        ST_CHECK,
`endif
        ST_DONE,
        ST_OVER
    } state_t;

    state_t     state_reg;
    logic [5:0] clr_cnt_reg;
    logic [5:0] move_cnt_reg;
    logic [2:0] height_reg [COLS];
    logic [2:0] col_reg;
    logic [2:0] row_reg;
    logic [1:0] player_reg;
    logic [1:0] winner_reg;
    logic       draw_reg;
    logic       err_reg;
    logic       col_bad;
    logic [5:0] write_cell;

    // Out-of-range columns are rejected before the height array is consulted.
    always_comb begin
        col_bad = 1'b1;
        if (int'(bus.move_col) < COLS)
            col_bad = (height_reg[bus.move_col] == 3'(ROWS));
    end

    assign write_cell     = 6'(int'(row_reg) * COLS + int'(col_reg));
    assign bus.move_ready = (state_reg == ST_IDLE) && !new_game;

    always_comb begin
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (state_reg)
            ST_CLEAR: begin
                bus.mem_we   = 1'b1;
                bus.mem_addr = ADDRESS_WIDTH'(clr_cnt_reg);
            end
            ST_WRITE: begin
                bus.mem_we    = 1'b1;
                bus.mem_addr  = ADDRESS_WIDTH'(write_cell);
                bus.mem_wdata = DATA_WIDTH'(player_reg);
            end
            default: ;
        endcase
    end

    assign busy      = (state_reg != ST_IDLE) && (state_reg != ST_OVER);
    assign move_done = (state_reg == ST_DONE);
    assign game_over = (state_reg == ST_OVER);
    assign move_err  = err_reg;
    assign player    = player_reg;
    assign winner    = winner_reg;
    assign draw      = draw_reg;

`ifdef WIN_CHECK_EN
    logic [1:0] dir_reg;
    logic [2:0] run_len;

    // Run length through the placed cell along the direction selected by dir_reg.
    always_comb begin
        int  dr;
        int  dc;
        int  r;
        int  c;
        int  sgn;
        logic go;
        run_len = 3'd1;
        dr      = 0;
        dc      = 1;
        r       = 0;
        c       = 0;
        sgn     = 1;
        go      = 1'b1;
        case (dir_reg)
            2'd0:    begin dr = 0; dc = 1;  end
            2'd1:    begin dr = 1; dc = 0;  end
            2'd2:    begin dr = 1; dc = 1;  end
            default: begin dr = 1; dc = -1; end
        endcase
        for (int s = 0; s < 2; s++) begin
            sgn = (s == 0) ? 1 : -1;
            go  = 1'b1;
            for (int k = 1; k <= 3; k++) begin
                r = int'(row_reg) + sgn * k * dr;
                c = int'(col_reg) + sgn * k * dc;
                if (go && r >= 0 && r < ROWS && c >= 0 && c < COLS) begin
                    if (board[(r*COLS + c)*DATA_WIDTH +: DATA_WIDTH] == DATA_WIDTH'(player_reg))
                        run_len = run_len + 3'd1;
                    else
                        go = 1'b0;
                end else begin
                    go = 1'b0;
                end
            end
        end
    end
`else
    logic unused_board;
    assign unused_board = ^board;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_CLEAR;
            clr_cnt_reg  <= '0;
            move_cnt_reg <= '0;
            for (int i = 0; i < COLS; i++) height_reg[i] <= '0;
            col_reg      <= '0;
            row_reg      <= '0;
            player_reg   <= 2'd1;
            winner_reg   <= 2'd0;
            draw_reg     <= 1'b0;
            err_reg      <= 1'b0;
`ifdef WIN_CHECK_EN
            dir_reg      <= '0;
`endif
        end else begin
            err_reg <= 1'b0;
            case (state_reg)
                ST_CLEAR: begin
                    clr_cnt_reg <= clr_cnt_reg + 6'd1;
                    if (clr_cnt_reg == 6'(CELLS - 1)) state_reg <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (bus.move_valid && bus.move_ready) begin
                        if (col_bad) begin
                            err_reg <= 1'b1;
                        end else begin
                            col_reg   <= bus.move_col;
                            row_reg   <= height_reg[bus.move_col];
                            state_reg <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    height_reg[col_reg] <= height_reg[col_reg] + 3'd1;
                    move_cnt_reg        <= move_cnt_reg + 6'd1;
`ifdef WIN_CHECK_EN
                    dir_reg   <= '0;
                    state_reg <= ST_CHECK;
`else
                    state_reg <= ST_DONE;
`endif
                end
`ifdef WIN_CHECK_EN
                ST_CHECK: begin
                    if (run_len >= 3'd4) winner_reg <= player_reg;
                    dir_reg <= dir_reg + 2'd1;
                    if (dir_reg == 2'd3) state_reg <= ST_DONE;
                end
`endif
                ST_DONE: begin
                    if (winner_reg != 2'd0 || move_cnt_reg == 6'(CELLS)) begin
                        if (winner_reg == 2'd0) draw_reg <= 1'b1;
                        state_reg <= ST_OVER;
                    end else begin
                        player_reg <= (player_reg == 2'd1) ? 2'd2 : 2'd1;
                        state_reg  <= ST_IDLE;
                    end
                end
                ST_OVER: ;
                default: state_reg <= ST_CLEAR;
            endcase

            // A restart overrides any move request seen in the same cycle.
            if (new_game && (state_reg == ST_IDLE || state_reg == ST_OVER)) begin
                state_reg    <= ST_CLEAR;
                clr_cnt_reg  <= '0;
                move_cnt_reg <= '0;
                for (int i = 0; i < COLS; i++) height_reg[i] <= '0;
                player_reg   <= 2'd1;
                winner_reg   <= 2'd0;
                draw_reg     <= 1'b0;
                err_reg      <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_c4_move_ctrl.sv
// Randomized bench for c4_move_ctrl: a per-cycle expectation queue built from a board-level model.
module tb_c4_move_ctrl;
    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int CELLS = 42;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            new_game = 1'b0;
    logic [DW*CELLS-1:0] board = '0;
    logic [1:0]      player, winner;
    logic            move_done, move_err, busy, game_over, draw;

    c4_move_ctrl_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    c4_move_ctrl #(.ROWS(6), .COLS(7), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .bus(bus), .new_game(new_game), .board(board),
        .player(player), .move_done(move_done), .move_err(move_err), .busy(busy),
        .game_over(game_over), .draw(draw), .winner(winner)
    );

    always #5 clk = ~clk;

    // Board RAM fixture: the DUT is its only writer.
    always @(posedge clk)
        if (bus.mem_we && int'(bus.mem_addr) < CELLS)
            board[int'(bus.mem_addr)*DW +: DW] <= bus.mem_wdata;

    typedef struct {
        logic ready, bsy, we, done, err, over, drw, chk_win;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [1:0]  plr, win;
    } exp_t;

    exp_t expq[$];

    int          cells [CELLS];
    int          mh [7];
    int          mcnt;
    logic [1:0]  m_player, m_winner;
    logic        m_draw, m_over;
    int          tests = 0;
    int          fails = 0;
    logic        chk_en = 1'b0;
    logic [7:0]  last_addr = '0;
    logic [31:0] last_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic exp_t steady();
        exp_t e;
        e.ready = !m_over; e.bsy = 1'b0; e.we = 1'b0; e.done = 1'b0; e.err = 1'b0;
        e.over = m_over; e.drw = m_draw; e.chk_win = 1'b1; e.addr = '0; e.wdata = '0;
        e.plr = m_player; e.win = m_winner;
        return e;
    endfunction

    function automatic exp_t clr_entry(input int k);
        exp_t e;
        e.ready = 1'b0; e.bsy = 1'b1; e.we = 1'b1; e.done = 1'b0; e.err = 1'b0;
        e.over = 1'b0; e.drw = 1'b0; e.chk_win = 1'b1; e.addr = 8'(k); e.wdata = '0;
        e.plr = 2'd1; e.win = 2'd0;
        return e;
    endfunction

    function automatic void model_reset();
        foreach (cells[i]) cells[i] = 0;
        foreach (mh[i]) mh[i] = 0;
        mcnt = 0; m_player = 2'd1; m_winner = 2'd0; m_draw = 1'b0; m_over = 1'b0;
    endfunction

    // Whole-board scan for any four in a row.
    function automatic logic [1:0] scan_win();
        int dr, dc, rr, cc, v;
        bit ok;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 7; c++)
                for (int d = 0; d < 4; d++) begin
                    v = cells[r*7 + c];
                    dr = (d == 0) ? 0 : 1;
                    dc = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
                    ok = (v != 0);
                    for (int k = 1; k <= 3; k++) begin
                        rr = r + k*dr; cc = c + k*dc;
                        if (rr < 0 || rr > 5 || cc < 0 || cc > 6) ok = 0;
                        else if (cells[rr*7 + cc] != v) ok = 0;
                    end
                    if (ok) return 2'(v);
                end
        return 2'd0;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            if (expq.size() > 0) e = expq.pop_front();
            else e = steady();
            chk("move_ready", 32'(bus.move_ready), 32'(e.ready));
            chk("busy",       32'(busy),           32'(e.bsy));
            chk("mem_we",     32'(bus.mem_we),     32'(e.we));
            if (e.we) begin
                chk("mem_addr",  32'(bus.mem_addr), 32'(e.addr));
                chk("mem_wdata", bus.mem_wdata,     e.wdata);
            end
            chk("move_done",  32'(move_done),      32'(e.done));
            chk("move_err",   32'(move_err),       32'(e.err));
            chk("game_over",  32'(game_over),      32'(e.over));
            chk("draw",       32'(draw),           32'(e.drw));
            chk("player",     32'(player),         32'(e.plr));
            if (e.chk_win) chk("winner", 32'(winner), 32'(e.win));
            if (bus.mem_we && bus.mem_wdata != 0) begin
                last_addr = bus.mem_addr;
                last_data = bus.mem_wdata;
            end
        end
    end

    task automatic push_clear();
        for (int k = 0; k < CELLS; k++) expq.push_back(clr_entry(k));
    endtask

    task automatic drain();
        int n = 0;
        while (expq.size() > 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_timeout", 32'(expq.size()), 32'd0);
        expq.delete();
    endtask

    // Caller is 1 time unit after a rising edge.
    task automatic do_reset();
        rst = 1'b1;
        expq.delete();
        model_reset();
        expq.push_back(clr_entry(0));
        expq.push_back(clr_entry(0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        push_clear();
        drain();
    endtask

    task automatic start_new_game(input bit with_move);
        exp_t e;
        @(posedge clk); #1;
        new_game = 1'b1;
        if (with_move) begin bus.move_valid = 1'b1; bus.move_col = 3'd0; end
        e = steady(); e.ready = 1'b0;
        expq.push_back(e);
        @(posedge clk); #1;
        new_game = 1'b0; bus.move_valid = 1'b0;
        model_reset();
        push_clear();
        drain();
    endtask

    task automatic move(input int col, input bit ng_noise);
        exp_t e;
        logic [1:0] p;
        @(posedge clk); #1;
        bus.move_valid = 1'b1; bus.move_col = 3'(col);
        @(posedge clk); #1;
        bus.move_valid = 1'b0;
        if (!m_over) begin
            if (col >= 7 || mh[col] == 6) begin
                e = steady(); e.err = 1'b1;
                expq.push_back(e);
            end else begin
                p = m_player;
                e = steady(); e.ready = 1'b0; e.bsy = 1'b1; e.we = 1'b1;
                e.addr = 8'(mh[col]*7 + col); e.wdata = 32'(p);
                expq.push_back(e);
`ifdef WIN_CHECK_EN
                e.we = 1'b0; e.chk_win = 1'b0;
                repeat (4) expq.push_back(e);
`endif
                cells[mh[col]*7 + col] = int'(p);
                mh[col]++;
                mcnt++;
`ifdef WIN_CHECK_EN
                m_winner = scan_win();
`endif
                e.we = 1'b0; e.chk_win = 1'b1; e.done = 1'b1; e.win = m_winner;
                expq.push_back(e);
                if (m_winner != 0 || mcnt == CELLS) begin
                    m_over = 1'b1;
                    m_draw = (m_winner == 0);
                end else begin
                    m_player = 2'd3 - p;
                end
                if (ng_noise) begin
                    new_game = 1'b1;
                    @(posedge clk); #1;
                    new_game = 1'b0;
                end
            end
        end
        drain();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int seq_h[7];
        int guard;
        bus.move_valid = 1'b0;
        bus.move_col   = 3'd0;
        model_reset();
        seq_h = '{0, 0, 1, 1, 2, 2, 3};

        // Reset and first clear
        @(posedge clk); #1;
        chk_en = 1'b1;
        expq.push_back(clr_entry(0));
        expq.push_back(clr_entry(0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        push_clear();
        drain();
        chk("t1_ready",  32'(bus.move_ready), 32'd1);
        chk("t1_player", 32'(player), 32'd1);
        chk("t1_busy",   32'(busy), 32'd0);

        // Two drops in column 3
        move(3, 1'b0);
        chk("t2_addr1", 32'(last_addr), 32'd3);
        chk("t2_data1", last_data, 32'd1);
        move(3, 1'b0);
        chk("t2_addr2", 32'(last_addr), 32'd10);
        chk("t2_data2", last_data, 32'd2);
        chk("t2_player", 32'(player), 32'd1);

        // Fill column 0, overflow, bad column, restart racing a move
        start_new_game(1'b0);
        for (int i = 0; i < 6; i++) move(0, 1'b0);
        chk("t3_addr_top", 32'(last_addr), 32'd35);
        chk("t3_model_h0", 32'(mh[0]), 32'd6);
        move(0, 1'b0);
        move(7, 1'b0);
        chk("t3_player", 32'(player), 32'd1);
        start_new_game(1'b1);

`ifndef WIN_CHECK_EN
        // Full board, no winner possible
        for (int i = 0; i < CELLS; i++) move(i % 7, 1'b0);
        chk("t4_draw",  32'(draw), 32'd1);
        chk("t4_over",  32'(game_over), 32'd1);
        chk("t4_ready", 32'(bus.move_ready), 32'd0);
        move(2, 1'b0);
        start_new_game(1'b0);
        chk("t4_player", 32'(player), 32'd1);
        chk("t4_draw0",  32'(draw), 32'd0);
`else
        // Horizontal then vertical four for player 1
        for (int i = 0; i < 7; i++) move(seq_h[i], 1'b0);
        chk("t5_model_win", 32'(m_winner), 32'd1);
        chk("t5_winner", 32'(winner), 32'd1);
        chk("t5_over",   32'(game_over), 32'd1);
        start_new_game(1'b0);
        for (int i = 0; i < 7; i++) move(i % 2, 1'b0);
        chk("t5_vwinner", 32'(winner), 32'd1);
        chk("t5_vover",   32'(game_over), 32'd1);
        start_new_game(1'b0);
`endif

        // Reset mid-clear, then reset during a WRITE
        begin
            exp_t e;
            @(posedge clk); #1;
            new_game = 1'b1;
            e = steady(); e.ready = 1'b0;
            expq.push_back(e);
            @(posedge clk); #1;
            new_game = 1'b0;
            model_reset();
            push_clear();
            repeat (20) begin @(posedge clk); #1; end
            do_reset();
        end
        move(2, 1'b0);
        move(4, 1'b0);
        @(posedge clk); #1;
        bus.move_valid = 1'b1; bus.move_col = 3'd5;
        @(posedge clk); #1;
        bus.move_valid = 1'b0;
        do_reset();
        move(2, 1'b0);
        chk("t6_addr", 32'(last_addr), 32'd2);
        chk("t6_data", last_data, 32'd1);

        // Random games
        for (int g = 0; g < 3; g++) begin
            start_new_game(1'b0);
            guard = 0;
            while (!m_over && guard < 150) begin
                move(int'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0));
                guard++;
            end
            chk("rnd_over", 32'(game_over), 32'(m_over));
            move(int'($urandom_range(0, 6)), 1'b0);
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
